// File: rtl/controlador_linha_envase.sv
// controlador_linha_envase: bottling-line sequencer with fill/cap timeouts, dozen counting and latched faults.
// Define CTRL_ESTOP_EN to add the estop input and fault code 4.
module controlador_linha_envase #(
   parameter int FILL_TIMEOUT = 1000,
   parameter int CAP_TIMEOUT  = 200,
   parameter int DOZEN_SIZE   = 12,
   parameter int DOZ_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             bottle_sensor,
   input  logic             level_sensor,
   input  logic             cap_done,
   input  logic             vat_low,
   input  logic             clear_fault,
   input  logic             count_clr,
`ifdef CTRL_ESTOP_EN
   input  logic             estop,
`endif
   output logic             motor,
   output logic             valve,
   output logic             capper,
   output logic             alarm,
   output logic [2:0]       fault_code,
   output logic [3:0]       bottles,
   output logic [DOZ_W-1:0] dozens,
   output logic             dozen_done,
   output logic [2:0]       state_o
);
   typedef enum logic [2:0] {IDLE = 3'd0, MOVE, FILL, CAP, COUNT, EXIT, FAULT} state_t;
   localparam int TMAX = FILL_TIMEOUT > CAP_TIMEOUT ? FILL_TIMEOUT : CAP_TIMEOUT;
   localparam int TW = $clog2(TMAX + 1);
   state_t state, nxt;
   logic [TW-1:0] timer;
   logic [2:0] code_n;
   logic stop_lat, clr_stop, estop_i, wrap;
`ifdef CTRL_ESTOP_EN
   assign estop_i = estop;
`else
   assign estop_i = 1'b0;
`endif
   assign motor   = state == MOVE || state == EXIT;
   assign valve   = state == FILL;
   assign capper  = state == CAP;
   assign alarm   = state == FAULT;
   assign state_o = state;
   assign wrap    = state == COUNT && bottles == 4'(DOZEN_SIZE - 1);
   always_comb begin
      nxt = state;
      code_n = fault_code;
      clr_stop = 1'b0;
      case (state)
         IDLE:  if (start && !vat_low) nxt = MOVE;
         MOVE:  if (stop_lat) begin nxt = IDLE; clr_stop = 1'b1; end
                else if (bottle_sensor) nxt = FILL;
         FILL:  if (vat_low) begin nxt = FAULT; code_n = 3'd3; end
                else if (level_sensor) nxt = CAP;
                else if (timer == TW'(FILL_TIMEOUT - 1)) begin nxt = FAULT; code_n = 3'd1; end
         CAP:   if (cap_done) nxt = COUNT;
                else if (timer == TW'(CAP_TIMEOUT - 1)) begin nxt = FAULT; code_n = 3'd2; end
         COUNT: nxt = EXIT;
         EXIT:  if (!bottle_sensor) begin nxt = stop_lat ? IDLE : MOVE; clr_stop = stop_lat; end
         FAULT: if (clear_fault && !vat_low && !estop_i) begin nxt = IDLE; code_n = 3'd0; clr_stop = 1'b1; end
         default: nxt = IDLE;
      endcase
      // emergency stop overrides every other transition
      if (estop_i && state != FAULT) begin
         nxt = FAULT;
         code_n = 3'd4;
         clr_stop = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         stop_lat   <= 1'b0;
         fault_code <= 3'd0;
         bottles    <= 4'd0;
         dozens     <= '0;
         dozen_done <= 1'b0;
      end else begin
         state      <= nxt;
         fault_code <= code_n;
         timer      <= nxt != state ? '0 : (state == FILL || state == CAP) ? timer + TW'(1) : timer;
         stop_lat   <= !clr_stop && (stop_lat || stop);
         dozen_done <= wrap && !count_clr;
         if (count_clr) begin
            bottles <= 4'd0;
            dozens  <= '0;
         end else if (state == COUNT) begin
            bottles <= wrap ? 4'd0 : bottles + 4'd1;
            if (wrap && dozens != '1) dozens <= dozens + DOZ_W'(1);
         end
      end
   end
endmodule
